instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 117 +++++++++++
 tb/tb_instr_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch with branch squash and held output
// Optional opcode legality check on the held word: define IFETCH_DECODE_CHECK_EN.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_pc,
   output logic        illegal_op
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state, state_nx;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic [31:0] tgt;
   logic        squash;
   logic        take;

   assign tgt = branch_target & ~32'h3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // A branch in REQ never cancels the bus cycle; it only poisons the returning data.
   always_comb begin
      state_nx = state;
      take     = 1'b0;
      case (state)
         IDLE: if (!stall) state_nx = REQ;
         REQ: begin
            if (imem_ack) begin
               if (!branch_en && !squash) begin
                  take     = 1'b1;
                  state_nx = HOLD;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         HOLD:    if (branch_en || instr_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign imem_req  = (state == REQ);
   assign imem_addr = (state == REQ) ? req_addr : pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         squash      <= 1'b0;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         instr_pc    <= 32'h0;
      end else begin
         if (state == IDLE && !stall) req_addr <= branch_en ? tgt : pc;

         if (branch_en)  pc <= tgt;
         else if (take)  pc <= req_addr + 32'd4;

         if (state == REQ) begin
            if (imem_ack)       squash <= 1'b0;
            else if (branch_en) squash <= 1'b1;
         end

         if (take) begin
            instr       <= imem_rdata;
            instr_pc    <= req_addr;
            instr_valid <= 1'b1;
         end else if (state == HOLD && (branch_en || instr_ready)) begin
            instr_valid <= 1'b0;
         end
      end
   end

`ifdef IFETCH_DECODE_CHECK_EN
   logic illegal_d;

   always_comb begin
      illegal_d = 1'b1;
      case (imem_rdata[31:26])
         6'b000101, 6'b000110: illegal_d = 1'b0;
         6'b000100: begin
            case (imem_rdata[5:0])
               6'b100000, 6'b100010, 6'b110010,
               6'b100100, 6'b100101: illegal_d = 1'b0;
               default:              illegal_d = 1'b1;
            endcase
         end
         default: illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    illegal_op <= 1'b0;
      else if (take) illegal_op <= illegal_d;
   end
`else
   assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_en;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_pc;
   logic        illegal_op;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .branch_en(branch_en), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_pc(instr_pc), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_ill(input logic [31:0] w);
`ifdef IFETCH_DECODE_CHECK_EN
      logic [5:0] op;
      logic [5:0] fn;
      op = w[31:26];
      fn = w[5:0];
      if (op == 6'h05 || op == 6'h06) return 1'b0;
      if (op == 6'h04)
         return !(fn == 6'h20 || fn == 6'h22 || fn == 6'h32 || fn == 6'h24 || fn == 6'h25);
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("instr", instr, e.word);
         chk("instr_pc", instr_pc, e.pc);
         chk("illegal_op", illegal_op, e.ill);
      end
   endtask

   task automatic push(input logic [31:0] w, input logic [31:0] a);
      sb.push_back('{word: w, pc: a, ill: exp_ill(w)});
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) chk("req_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                           input int dly, input logic stall_in_req);
      wait_req();
      chk("req_addr", imem_addr, addr);
      if (stall_in_req) stall = 1'b1;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk("req_hold", imem_req, 32'd1);
         chk("addr_hold", imem_addr, addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      push(data, addr);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk("valid", instr_valid, 32'd1);
      pop_cmp();
      chk("next_addr", imem_addr, addr + 32'd4);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      stall       = 1'b0;
      chk("consumed", instr_valid, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b1; branch_en = 1'b0; branch_target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", instr_valid, 32'd0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_ill", illegal_op, 32'd0);

      // first fetch: two-cycle latency, then hold against back-pressure
      rst_n = 1'b1; stall = 1'b0;
      @(negedge clk);
      chk("first_req", imem_req, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'h15C0_0C00; push(32'h15C0_0C00, 32'h0);
      @(negedge clk);
      imem_ack = 1'b0;
      chk("latency_valid", instr_valid, 32'd1);
      pop_cmp();
      chk("first_next_addr", imem_addr, 32'h4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_instr", instr, 32'h15C0_0C00);
         chk("hold_valid", instr_valid, 32'd1);
         chk("hold_req", imem_req, 32'd0);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      chk("release_valid", instr_valid, 32'd0);

      do_fetch(32'h4, 32'h1002_0000, 2, 1'b1);
      do_fetch(32'h8, 32'h1043_2820, 0, 1'b0);

      // branch during REQ, ack three cycles later is squashed
      wait_req();
      chk("sq_addr", imem_addr, 32'hC);
      branch_en = 1'b1; branch_target = 32'h0000_0103;
      @(negedge clk);
      branch_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("sq_req_hold", imem_req, 32'd1);
         chk("sq_addr_hold", imem_addr, 32'hC);
         @(negedge clk);
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("sq_valid", instr_valid, 32'd0);
      chk("sq_req", imem_req, 32'd0);
      do_fetch(32'h100, 32'h1400_0001, 1, 1'b0);

      // same-cycle ack and branch
      wait_req();
      chk("race_addr", imem_addr, 32'h104);
      imem_ack = 1'b1; imem_rdata = 32'h1043_2820;
      branch_en = 1'b1; branch_target = 32'h0000_0200;
      @(negedge clk);
      imem_ack = 1'b0; branch_en = 1'b0;
      chk("race_valid", instr_valid, 32'd0);
      chk("race_req", imem_req, 32'd0);
      do_fetch(32'h200, 32'h1800_0000, 0, 1'b0);

      // branch in HOLD drops the instruction even with ready
      wait_req();
      chk("hb_addr", imem_addr, 32'h204);
      imem_ack = 1'b1; imem_rdata = 32'h1043_2822; push(32'h1043_2822, 32'h204);
      @(negedge clk);
      imem_ack = 1'b0;
      chk("hb_valid", instr_valid, 32'd1);
      pop_cmp();
      branch_en = 1'b1; instr_ready = 1'b1; branch_target = 32'h0000_0301;
      @(negedge clk);
      branch_en = 1'b0; instr_ready = 1'b0;
      chk("hb_drop", instr_valid, 32'd0);
      do_fetch(32'h300, 32'h1443_0000, 0, 1'b0);

      // branch in stalled IDLE, then wrap at the top of the address space
      stall = 1'b1;
      @(negedge clk);
      chk("stall_req", imem_req, 32'd0);
      branch_en = 1'b1; branch_target = 32'hFFFF_FFFF;
      @(negedge clk);
      branch_en = 1'b0;
      chk("stall_req2", imem_req, 32'd0);
      chk("idle_branch_pc", imem_addr, 32'hFFFF_FFFC);
      stall = 1'b0;
      do_fetch(32'hFFFF_FFFC, 32'h1043_2832, 1, 1'b0);
      do_fetch(32'h0, 32'h1043_2825, 0, 1'b0);

      // reset mid-request abandons it; ack in IDLE is ignored
      wait_req();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", imem_req, 32'd0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_pc", instr_pc, 32'h0);
      @(negedge clk);
      stall = 1'b1; rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1400_0000;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("idle_ack_valid", instr_valid, 32'd0);
      chk("idle_ack_req", imem_req, 32'd0);
      stall = 1'b0;
      do_fetch(32'h0, 32'h1800_00FF, 0, 1'b0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
